// File: rtl/mu0_pkg.sv
// Shared MU0 definitions: opcodes, ALU function encodings and control states.
package mu0_pkg;

    localparam logic [3:0] OP_LDA = 4'd0;
    localparam logic [3:0] OP_STO = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_JMP = 4'd4;
    localparam logic [3:0] OP_JGE = 4'd5;
    localparam logic [3:0] OP_JNE = 4'd6;
    localparam logic [3:0] OP_STP = 4'd7;

    typedef enum logic [1:0] {
        ALU_PASS_Y = 2'b00,
        ALU_ADD    = 2'b01,
        ALU_SUB    = 2'b10,
        ALU_INC    = 2'b11
    } alu_fs_e;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        EXECUTE = 2'd1,
        HALT    = 2'd2
    } state_e;

endpackage

// File: rtl/mu0_control_if.sv
// Control bundle between the MU0 sequencer (master) and datapath/memory (slave).
interface mu0_control_if;

    logic [3:0] F;
    logic       N;
    logic       Z;
    logic       mem_ack;
    logic       Addr_sel;
    logic       X_sel;
    logic       Y_sel;
    logic [1:0] ALU_fs;
    logic       ACC_load;
    logic       PC_load;
    logic       IR_load;
    logic       Rd;
    logic       Wr;
    logic       Halted;
    logic       bus_err;
    logic       illegal_op;

    modport master (
        input  F, N, Z, mem_ack,
        output Addr_sel, X_sel, Y_sel, ALU_fs, ACC_load, PC_load, IR_load,
               Rd, Wr, Halted, bus_err, illegal_op
    );

    modport slave (
        output F, N, Z, mem_ack,
        input  Addr_sel, X_sel, Y_sel, ALU_fs, ACC_load, PC_load, IR_load,
               Rd, Wr, Halted, bus_err, illegal_op
    );

endinterface

// File: rtl/mu0_wait_timer.sv
// Memory wait-state watchdog: flags the WAIT_MAX-th consecutive unacknowledged access cycle.
module mu0_wait_timer #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic Clk,
    input  logic Reset,
    input  logic access,
    input  logic mem_ack,
    input  logic state_change,
    output logic timeout
);

    localparam int unsigned W = $clog2(WAIT_MAX + 1);
    localparam logic [W-1:0] LIMIT = W'(WAIT_MAX);
    localparam logic [W-1:0] LAST  = W'(WAIT_MAX - 1);

    logic [W-1:0] count;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            count <= '0;
        end else if (mem_ack || state_change) begin
            count <= '0;
        end else if (access && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    // count holds the unacknowledged cycles already seen, so this is the WAIT_MAX-th
    assign timeout = access && !mem_ack && (count == LAST);

endmodule

// File: rtl/mu0_control.sv
// MU0 sequencing control: fetch/execute FSM, strobe decode, sticky error flags.
module mu0_control
    import mu0_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic          Clk,
    input  logic          Reset,
    mu0_control_if.master bus
);

    state_e  state, next_state;
    alu_fs_e alu_fs;
    logic    addr_sel, x_sel, y_sel;
    logic    acc_load, pc_load, ir_load, rd, wr;
    logic    set_ill, timeout;
    logic    bus_err_q, illegal_q;

    mu0_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait (
        .Clk          (Clk),
        .Reset        (Reset),
        .access       (rd | wr),
        .mem_ack      (bus.mem_ack),
        .state_change (next_state != state),
        .timeout      (timeout)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= FETCH;
            bus_err_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state <= next_state;
            if (timeout) bus_err_q <= 1'b1;
            if (set_ill) illegal_q <= 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        alu_fs     = ALU_PASS_Y;
        addr_sel   = 1'b0;
        x_sel      = 1'b0;
        y_sel      = 1'b0;
        acc_load   = 1'b0;
        pc_load    = 1'b0;
        ir_load    = 1'b0;
        rd         = 1'b0;
        wr         = 1'b0;
        set_ill    = 1'b0;
        unique case (state)
            FETCH: begin
                rd      = 1'b1;
                x_sel   = 1'b1;
                alu_fs  = ALU_INC;
                ir_load = bus.mem_ack;
                pc_load = bus.mem_ack;
                if (bus.mem_ack) next_state = EXECUTE;
            end
            EXECUTE: begin
                unique case (bus.F)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        addr_sel = 1'b1;
                        rd       = 1'b1;
                        acc_load = bus.mem_ack;
                        alu_fs   = (bus.F == OP_LDA) ? ALU_PASS_Y :
                                   (bus.F == OP_ADD) ? ALU_ADD : ALU_SUB;
                        if (bus.mem_ack) next_state = FETCH;
                    end
                    OP_STO: begin
                        addr_sel = 1'b1;
                        wr       = 1'b1;
                        if (bus.mem_ack) next_state = FETCH;
                    end
                    OP_JMP, OP_JGE, OP_JNE: begin
                        y_sel      = 1'b1;
                        pc_load    = (bus.F == OP_JMP) ? 1'b1 :
                                     (bus.F == OP_JGE) ? !bus.N : !bus.Z;
                        next_state = FETCH;
                    end
                    OP_STP: next_state = HALT;
                    default: begin
                        set_ill    = 1'b1;
                        next_state = FETCH;
                    end
                endcase
            end
            HALT: ;
            default: next_state = FETCH;
        endcase
        if (timeout) next_state = HALT;
    end

    // state sits at FETCH throughout reset, so strobes are gated here to stay low
    assign bus.Addr_sel   = addr_sel & ~Reset;
    assign bus.X_sel      = x_sel & ~Reset;
    assign bus.Y_sel      = y_sel & ~Reset;
    assign bus.ALU_fs     = Reset ? 2'b00 : alu_fs;
    assign bus.ACC_load   = acc_load & ~Reset;
    assign bus.PC_load    = pc_load & ~Reset;
    assign bus.IR_load    = ir_load & ~Reset;
    assign bus.Rd         = rd & ~Reset;
    assign bus.Wr         = wr & ~Reset;
    assign bus.Halted     = (state == HALT) & ~Reset;
    assign bus.bus_err    = bus_err_q;
    assign bus.illegal_op = illegal_q;

endmodule

// File: tb/tb_mu0_control.sv
// Scoreboard bench for mu0_control: directed scenarios plus random traffic vs. a cycle model.
module tb_mu0_control;

    localparam int WAIT_MAX = 15;

    logic Clk;
    logic Reset;
    mu0_control_if bus();

    mu0_control #(.WAIT_MAX(WAIT_MAX)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.master)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // model: phase 0 = fetch, 1 = execute, 2 = halted
    int          m_phase;
    int          m_waits;
    bit          m_ill;
    bit          m_berr;
    logic [12:0] exp_q[$];
    int          checks;
    int          errors;
    int          cyc;

    // order: Addr_sel X_sel Y_sel ALU_fs[1:0] ACC_load PC_load IR_load Rd Wr Halted bus_err illegal_op
    task automatic step(input logic [3:0] f, input logic n, input logic z,
                        input logic ack, input logic rst);
        logic       a_sel, x, y, acc, pc, ir, rd, wr, hlt;
        logic [1:0] fs;
        int         nxt;
        @(posedge Clk);
        #1;
        bus.F       = f;
        bus.N       = n;
        bus.Z       = z;
        bus.mem_ack = ack;
        Reset       = rst;
        {a_sel, x, y, acc, pc, ir, rd, wr, hlt} = '0;
        fs = 2'b00;
        if (rst) begin
            m_phase = 0;
            m_waits = 0;
            m_ill   = 0;
            m_berr  = 0;
            exp_q.push_back(13'b0);
        end else begin
            nxt = m_phase;
            if (m_phase == 0) begin
                rd = 1; x = 1; fs = 2'b11; ir = ack; pc = ack;
                if (ack) nxt = 1;
            end else if (m_phase == 1) begin
                case (f)
                    4'd0: begin a_sel = 1; rd = 1; acc = ack; fs = 2'b00; nxt = ack ? 0 : 1; end
                    4'd1: begin a_sel = 1; wr = 1; nxt = ack ? 0 : 1; end
                    4'd2: begin a_sel = 1; rd = 1; acc = ack; fs = 2'b01; nxt = ack ? 0 : 1; end
                    4'd3: begin a_sel = 1; rd = 1; acc = ack; fs = 2'b10; nxt = ack ? 0 : 1; end
                    4'd4: begin y = 1; pc = 1;  nxt = 0; end
                    4'd5: begin y = 1; pc = !n; nxt = 0; end
                    4'd6: begin y = 1; pc = !z; nxt = 0; end
                    4'd7: nxt = 2;
                    default: nxt = 0;
                endcase
            end else begin
                hlt = 1;
            end
            exp_q.push_back({a_sel, x, y, fs, acc, pc, ir, rd, wr, hlt, m_berr, m_ill});
            if (m_phase == 1 && f >= 4'd8) m_ill = 1;
            if (ack) m_waits = 0;
            else if (rd || wr) begin
                m_waits++;
                if (m_waits == WAIT_MAX) begin
                    nxt    = 2;
                    m_berr = 1;
                end
            end
            if (nxt != m_phase) m_waits = 0;
            m_phase = nxt;
        end
    endtask

    initial begin : monitor
        logic [12:0] e, a;
        forever begin
            @(negedge Clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {bus.Addr_sel, bus.X_sel, bus.Y_sel, bus.ALU_fs, bus.ACC_load,
                     bus.PC_load, bus.IR_load, bus.Rd, bus.Wr, bus.Halted,
                     bus.bus_err, bus.illegal_op};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL cycle %0d outputs: got %b expected %b (F=%h N=%b Z=%b ack=%b rst=%b)",
                             cyc, a, e, bus.F, bus.N, bus.Z, bus.mem_ack, Reset);
                end
                cyc++;
            end
        end
    end

    initial begin : driver
        bit slow;
        logic [3:0] f;
        checks      = 0;
        errors      = 0;
        cyc         = 0;
        Reset       = 1'b1;
        bus.F       = 4'd0;
        bus.N       = 1'b0;
        bus.Z       = 1'b0;
        bus.mem_ack = 1'b0;

        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 1);
        // zero-wait LDA
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        // conditional jumps: JGE N=1, JGE N=0, JNE Z=1, JNE Z=0, JMP
        step(5, 1, 0, 1, 0); step(5, 1, 0, 1, 0);
        step(5, 0, 1, 1, 0); step(5, 0, 1, 1, 0);
        step(6, 0, 1, 1, 0); step(6, 0, 1, 1, 0);
        step(6, 1, 0, 1, 0); step(6, 1, 0, 1, 0);
        step(4, 1, 1, 1, 0); step(4, 1, 1, 1, 0);
        // three fetch wait states then ADD with two waits, SUB zero-wait
        for (int i = 0; i < 3; i++) step(2, 0, 0, 0, 0);
        step(2, 0, 0, 1, 0);
        step(2, 0, 0, 0, 0); step(2, 0, 0, 0, 0); step(2, 0, 0, 1, 0);
        step(3, 0, 0, 1, 0); step(3, 0, 0, 1, 0);
        // watchdog: never acknowledged
        for (int i = 0; i < WAIT_MAX + 4; i++) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        // acknowledged on the WAIT_MAX-th cycle: no error
        for (int i = 0; i < WAIT_MAX - 1; i++) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        // watchdog on a store's execute cycle
        step(1, 0, 0, 1, 0);
        for (int i = 0; i < WAIT_MAX + 1; i++) step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        // illegal opcode, then stop
        step(4'hA, 0, 0, 1, 0); step(4'hA, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);    step(0, 0, 0, 1, 0);
        step(7, 0, 0, 1, 0);    step(7, 0, 0, 1, 0);
        for (int i = 0; i < 20; i++) step(4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'($urandom), 0);
        step(0, 0, 0, 1, 1);
        // reset during a stalled STO execute
        step(1, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);

        slow = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) slow = !slow;
            f = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
            step(f, 1'($urandom), 1'($urandom),
                 slow ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 9) < 7),
                 (m_phase == 2) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 149) == 0));
        end

        @(negedge Clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mu0_control.md
# mu0_control

Sequencing control unit for the MU0 datapath. It decodes the 4-bit opcode from the instruction register and drives the datapath strobes, including `Addr_sel`, the select of the 12-bit address multiplexer (PC vs IR[11:0]). It runs a fetch/execute state machine with a memory acknowledge handshake and a wait-state watchdog. It sits directly upstream of the address mux, the ALU and the PC/IR/ACC registers.

## Interface
**Parameters**
- `WAIT_MAX`, default 15: consecutive unacknowledged access cycles tolerated before a bus error. Range 1..255.

**Ports**
- `Clk` in 1: single clock, rising edge.
- `Reset` in 1: asynchronous, active-high reset.
- `F` in 4: opcode, IR[15:12].
- `N` in 1: accumulator negative flag.
- `Z` in 1: accumulator zero flag.
- `mem_ack` in 1: memory completes the current Rd/Wr this cycle.
- `Addr_sel` out 1: 0 selects PC, 1 selects IR[11:0] onto the address bus.
- `X_sel` out 1: ALU X operand; 0 = ACC, 1 = PC.
- `Y_sel` out 1: ALU Y operand; 0 = memory data, 1 = IR[11:0].
- `ALU_fs` out 2: 00 PASS_Y, 01 ADD, 10 SUB, 11 INC (X+1).
- `ACC_load`, `PC_load`, `IR_load` out 1 each: register load enables.
- `Rd`, `Wr` out 1 each: memory strobes.
- `Halted` out 1: processor stopped.
- `bus_err` out 1: sticky watchdog error.
- `illegal_op` out 1: sticky undefined-opcode flag.

## Operation
- **States.** FETCH, EXECUTE, HALT. The state register and sticky flags are the only storage apart from the wait counter.
- **FETCH.**
  - Outputs: `Addr_sel`=0, `Rd`=1, `X_sel`=1, `ALU_fs`=INC.
  - `IR_load` = `PC_load` = `mem_ack`.
  - Transition: `mem_ack` → EXECUTE; otherwise stay.
- **EXECUTE, by opcode `F`:**
  - 0 LDA: `Addr_sel`=1, `Rd`=1, `Y_sel`=0, PASS_Y, `ACC_load`=`mem_ack`.
  - 1 STO: `Addr_sel`=1, `Wr`=1.
  - 2 ADD: as LDA, with `X_sel`=0 and ADD.
  - 3 SUB: as ADD, with SUB.
  - 4 JMP: `Y_sel`=1, PASS_Y, `PC_load`=1, no memory access.
  - 5 JGE: as JMP, with `PC_load`=!N.
  - 6 JNE: as JMP, with `PC_load`=!Z.
  - 7 STP: no strobes; next state HALT.
  - 8–15: no strobes; set `illegal_op`; next state FETCH.
- **EXECUTE transitions.** Memory opcodes (0–3) go to FETCH on `mem_ack`, otherwise stay. Jumps and illegal opcodes go to FETCH unconditionally after one cycle.
- **HALT.**
  - Outputs: all strobes and enables 0, `Addr_sel`=0, `Halted`=1.
  - Exit only by `Reset`.
- **Don't-care outputs.** Any output not listed for a state is driven 0.
- **Strobe decode.** `Rd`, `Wr` and the enables are combinational from state, `F`, `N`, `Z` and `mem_ack`. They never glitch from state changes mid-cycle, because the state is registered.
- **Watchdog.**
  - The counter is `$clog2(WAIT_MAX+1)` bits wide.
  - It increments on each access cycle (`Rd` or `Wr` high) with `mem_ack`=0.
  - It clears on any cycle with `mem_ack`=1 and on every state change.
  - When the count reaches WAIT_MAX−1 and `mem_ack` is still 0, the next state is HALT and `bus_err` is set. The bus error is therefore taken on the WAIT_MAX-th unacknowledged cycle.
  - If `mem_ack` is 1 in that same cycle, `mem_ack` wins: normal transition, no error.
  - The counter saturates and never wraps.
- **Sticky flags.** `illegal_op` and `bus_err` clear only on `Reset`.

## Timing
- **During reset.** While `Reset`=1, asynchronously:
  - state = FETCH; counter = 0; `bus_err` = `illegal_op` = 0.
  - All strobes and enables are forced 0; `Addr_sel`=0; `Halted`=0.
- **Reset release.** The first rising edge after release starts FETCH, with `Rd` asserted from that cycle.
- **Mid-instruction reset.** Asserting `Reset` in the middle of an instruction immediately deasserts `Rd`/`Wr`. There is no completion of the pending access.
- **Instruction latency.** With zero-wait memory: 2 cycles per instruction (FETCH + EXECUTE), 2 cycles for jumps, and STP reaches HALT after 2 cycles. Each wait cycle adds 1.
- **Handshake.** The memory must hold its data valid in the cycle `mem_ack`=1. The controller holds `Addr_sel`, `Rd` and `Wr` stable until that cycle.
- **Flag sampling.** `N` and `Z` are sampled combinationally in the JGE/JNE EXECUTE cycle.

## Structure
- **Shared package `mu0_pkg`.** Holds:
  - opcode constants (LDA..STP);
  - the `ALU_fs` encodings (PASS_Y, ADD, SUB, INC);
  - the state enum (FETCH, EXECUTE, HALT).
- **Sub-module `mu0_wait_timer`.**
  - Inputs: `Clk`, `Reset`, access, `mem_ack`, state_change.
  - Output: `timeout`.
  - Parameterised by WAIT_MAX.
- **Top level.** State register, sticky flags and output decode.

## Test plan
- **Zero-wait LDA.** Reset, then `mem_ack` tied to 1 and `F`=0 (LDA 0x005).
  - Cycle 1: `Addr_sel`=0, `Rd`=1, `IR_load`=`PC_load`=1, `ALU_fs`=11.
  - Cycle 2: `Addr_sel`=1, `Rd`=1, `ACC_load`=1, `ALU_fs`=00.
- **Conditional jumps.**
  - JGE with N=1: `PC_load`=0, then FETCH.
  - JGE with N=0: `PC_load`=1, `Y_sel`=1.
  - JNE with Z=1: `PC_load`=0.
- **Wait states.** `mem_ack` low for 3 FETCH cycles, then high: `Rd`=1 and `Addr_sel`=0 for all 4 cycles, `IR_load` only in cycle 4, EXECUTE on cycle 5.
- **Watchdog.** WAIT_MAX=15 and `mem_ack` never asserted: `Halted`=1 and `bus_err`=1 after exactly 15 `Rd` cycles. Repeat with `mem_ack`=1 on cycle 15: no error.
- **Illegal opcode and stop.** `F`=4'hA gives a 1-cycle EXECUTE with no strobes, `illegal_op`=1 held, then FETCH. `F`=7 gives `Halted`=1, held for 20 cycles until `Reset`.
- **Asynchronous reset.** `Reset` pulsed mid-EXECUTE of STO (`Wr`=1): `Wr` drops in the same cycle, flags clear, and FETCH resumes on the first edge after release.
